// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared widths and FSM encodings for the hazard controller
package pipe_hazard_ctrl_pkg;
    localparam int PHC_REG_ADDR_W = 5;
    typedef enum logic {PHC_RUN = 1'b0, PHC_MDU_WAIT = 1'b1} phc_state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from the pipeline and stall/flush controls back to it
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = PHC_REG_ADDR_W,
    parameter int CNT_W = 32
);
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic id_rs1_used;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic id_rs2_used;
    logic id_ex_mem_read;
    logic [REG_ADDR_W-1:0] id_ex_reg_waddr;
    logic ex_redirect;
    logic ex_mdu_start;
    logic ex_mdu_done;
    logic imem_busy;
    logic dmem_busy;
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic ex_mem_flush;
    logic mem_wb_flush;
    logic mdu_busy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used, id_ex_mem_read,
               id_ex_reg_waddr, ex_redirect, ex_mdu_start, ex_mdu_done, imem_busy, dmem_busy,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
               ex_mem_flush, mem_wb_flush, mdu_busy, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used, id_ex_mem_read,
               id_ex_reg_waddr, ex_redirect, ex_mdu_start, ex_mdu_done, imem_busy, dmem_busy,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
               ex_mem_flush, mem_wb_flush, mdu_busy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// hazard_perf_cnt: wrapping event counter with synchronous clear
module hazard_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    // clear dominates; otherwise count qualifying cycles, wrapping naturally
    always_ff @(posedge clk) begin
        if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: prioritised stall/flush generation for a five-stage pipeline
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = PHC_REG_ADDR_W,
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    phc_state_t state, state_nxt;
    logic mdu_hold, load_use, redirect_taken;

    assign mdu_hold = (state == PHC_RUN) ? bus.ex_mdu_start : ~bus.ex_mdu_done;
    assign load_use = bus.id_ex_mem_read && bus.id_ex_reg_waddr != X0 &&
                      ((bus.id_rs1_used && bus.id_rs1_addr == bus.id_ex_reg_waddr) ||
                       (bus.id_rs2_used && bus.id_rs2_addr == bus.id_ex_reg_waddr));
    assign redirect_taken = ~rst & ~bus.dmem_busy & ~mdu_hold & bus.ex_redirect;
    assign bus.mdu_busy = ~rst & (state == PHC_MDU_WAIT);

    // state register; a stalled MEM stage freezes the MDU handshake
    always_ff @(posedge clk) begin
        if (rst) state <= PHC_RUN;
        else state <= state_nxt;
    end

    // next state: enter on start, leave on done, both only when MEM is not stalled
    always_comb begin
        state_nxt = state;
        if (!bus.dmem_busy) begin
            if (state == PHC_RUN && bus.ex_mdu_start) state_nxt = PHC_MDU_WAIT;
            if (state == PHC_MDU_WAIT && bus.ex_mdu_done) state_nxt = PHC_RUN;
        end
    end

    // fixed-priority stall/flush selection; reset flushes every register
    always_comb begin
        bus.pc_stall = 1'b0;
        bus.if_id_stall = 1'b0;
        bus.if_id_flush = 1'b0;
        bus.id_ex_stall = 1'b0;
        bus.id_ex_flush = 1'b0;
        bus.ex_mem_stall = 1'b0;
        bus.ex_mem_flush = 1'b0;
        bus.mem_wb_flush = 1'b0;
        if (rst) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
            bus.ex_mem_flush = 1'b1;
            bus.mem_wb_flush = 1'b1;
        end else if (bus.dmem_busy) begin
            bus.pc_stall = 1'b1;
            bus.if_id_stall = 1'b1;
            bus.id_ex_stall = 1'b1;
            bus.ex_mem_stall = 1'b1;
            bus.mem_wb_flush = 1'b1;
        end else if (mdu_hold) begin
            bus.pc_stall = 1'b1;
            bus.if_id_stall = 1'b1;
            bus.id_ex_stall = 1'b1;
            bus.ex_mem_flush = 1'b1;
        end else if (bus.ex_redirect) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (load_use) begin
            bus.pc_stall = 1'b1;
            bus.if_id_stall = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (bus.imem_busy) begin
            bus.pc_stall = 1'b1;
            bus.if_id_flush = 1'b1;
        end
    end

    hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .clr(rst), .inc(bus.pc_stall), .cnt(bus.stall_cnt)
    );

    hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk(clk), .clr(rst), .inc(redirect_taken), .cnt(bus.flush_cnt)
    );
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller. Generates the stall and flush controls consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves the following hazards with a fixed priority:
  - data-memory wait
  - multi-cycle MDU operation in EX
  - branch/jump redirect from EX
  - load-use hazard
  - instruction-memory wait
- Drives all flushes during reset, so pipeline registers need no reset of their own.
- Keeps free-running stall and flush performance counters.

Parameters:
- REG_ADDR_W, 5, register-address width.
- CNT_W, 32, performance-counter width.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- id_rs1_addr  in  REG_ADDR_W  rs1 address of the instruction in ID.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_addr  in  REG_ADDR_W  rs2 address of the instruction in ID.
- id_rs2_used  in  1  ID instruction reads rs2.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_reg_waddr  in  REG_ADDR_W  destination of the instruction in EX.
- ex_redirect  in  1  taken branch or jump resolved in EX.
- ex_mdu_start  in  1  MDU instruction entered EX this cycle (single-cycle pulse).
- ex_mdu_done  in  1  MDU result valid; held high until EX advances.
- imem_busy  in  1  instruction fetch not complete.
- dmem_busy  in  1  data access in MEM not complete.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID.
- if_id_flush  out  1  clear IF/ID.
- id_ex_stall  out  1  hold ID/EX.
- id_ex_flush  out  1  clear ID/EX.
- ex_mem_stall  out  1  hold EX/MEM.
- ex_mem_flush  out  1  clear EX/MEM.
- mem_wb_flush  out  1  clear MEM/WB (bubble into WB).
- mdu_busy  out  1  FSM is in MDU_WAIT.
- stall_cnt  out  CNT_W  number of cycles with pc_stall=1.
- flush_cnt  out  CNT_W  number of redirect cycles.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Output timing:
  - All stall/flush outputs are combinational from the inputs and the registered state; they take effect at the same edge.
  - FSM state and counters are registered.
- While rst=1:
  - All *_flush=1 and all *_stall=0.
  - Next state is RUN; stall_cnt and flush_cnt are cleared to 0 on the edge.
  - mdu_busy=0 during the reset cycle.
- No register ever receives stall=1 and flush=1 in the same cycle. Where two cases conflict, stall wins.
- FSM states: RUN and MDU_WAIT.
  - RUN -> MDU_WAIT when ex_mdu_start=1 and dmem_busy=0.
  - MDU_WAIT -> RUN when ex_mdu_done=1 and dmem_busy=0.
  - ex_mdu_start arriving while in MDU_WAIT is ignored.
- Derived term: mdu_hold = (RUN & ex_mdu_start) | (MDU_WAIT & ~ex_mdu_done).
- Per-cycle priority (first matching case applies; outputs not listed are 0):
  - P1, dmem_busy: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1; mem_wb_flush=1. Redirect is suppressed; EX holds the branch, so it re-asserts later.
  - P2, mdu_hold: pc_stall, if_id_stall, id_ex_stall = 1; ex_mem_flush=1.
  - P3, ex_redirect: if_id_flush=1, id_ex_flush=1, pc_stall=0. PC loads the target even if imem_busy=1; the fetch unit aborts.
  - P4, load-use: pc_stall=1, if_id_stall=1, id_ex_flush=1.
    - Condition: id_ex_mem_read & (id_ex_reg_waddr!=0) & ((id_rs1_used & rs1 match) | (id_rs2_used & rs2 match)).
    - Exactly one bubble is inserted; the next cycle the load is in MEM, so no hazard remains.
  - P5, imem_busy: pc_stall=1, if_id_flush=1.
- Counters:
  - stall_cnt increments on every non-reset cycle with pc_stall=1.
  - flush_cnt increments on every non-reset cycle where P3 is applied.
  - Both wrap modulo 2^CNT_W.
- If reset is asserted in the middle of an MDU_WAIT, the FSM returns to RUN. The MDU is reset independently.

Decomposition:
- Shared defines file: REG_ADDR_W default and the state encodings PHC_RUN=1'b0 and PHC_MDU_WAIT=1'b1.
- Sub-module hazard_perf_cnt: a wrapping counter with clear and increment inputs, instantiated twice (stall and flush).

Test Plan:
- Reset:
  - Hold rst=1 for 2 cycles with all inputs toggling -> all flushes=1, all stalls=0.
  - After release -> stall_cnt=0, flush_cnt=0, mdu_busy=0.
- Load-use:
  - id_ex_mem_read=1, id_ex_reg_waddr=5, id_rs2_addr=5, id_rs2_used=1 -> exactly one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1.
  - Same stimulus with waddr=0 -> no stall.
- MDU:
  - ex_mdu_start pulse, ex_mdu_done rises 4 cycles later -> stalls held for 4 cycles with ex_mem_flush=1; mdu_busy=1 for 4 cycles; stall_cnt=4.
- dmem_busy during MDU_WAIT:
  - dmem_busy=1 overlaps the ex_mdu_done cycle -> ex_mem_stall=1 and mem_wb_flush=1.
  - FSM stays in MDU_WAIT until dmem_busy=0, then returns to RUN.
- Redirect:
  - ex_redirect=1 together with imem_busy=1 and a load-use condition -> if_id_flush=1, id_ex_flush=1, pc_stall=0; flush_cnt increments by 1.
- Counter wrap:
  - Build with CNT_W=4; drive 17 cycles of imem_busy=1 -> stall_cnt=1.
